// File: rtl/shift_pipe_stage.sv
// Two-stage pipelined 16-bit shift/rotate unit with valid/ready on both sides.
// Optional feature macro: SHIFT_ROTATE_EN enables ROL/ROR; otherwise those opcodes are illegal.

module shift_pipe_step #(
    parameter int W     = 16,
    parameter int SCALE = 0
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] data,
    input  logic [1:0]   amt,
    output logic [W-1:0] shifted
);
    localparam int SW = $clog2(W);

    // Each step handles two amount bits, weighted by 2**SCALE.
    logic [SW-1:0] n;
    assign n = SW'(amt) << SCALE;

`ifdef SHIFT_ROTATE_EN
    logic [2*W-1:0] dbl;
`endif

    always_comb begin
        shifted = '0;
`ifdef SHIFT_ROTATE_EN
        dbl = {data, data};
`endif
        case (op)
            3'b000: shifted = data << n;
            3'b001: shifted = data >> n;
            3'b010: shifted = $unsigned($signed(data) >>> n);
`ifdef SHIFT_ROTATE_EN
            3'b011: begin
                dbl     = {data, data} << n;
                shifted = dbl[2*W-1:W];
            end
            3'b100: begin
                dbl     = {data, data} >> n;
                shifted = dbl[W-1:0];
            end
`endif
            default: shifted = '0;
        endcase
    end
endmodule

module shift_pipe_stage #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] In,
    input  logic [SHAMT_WIDTH-1:0]   ShAmt,
    input  logic [2:0]               Op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] result,
    output logic                     err
);
    localparam int W      = OPERAND_WIDTH;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [2:0]   op;
        logic [1:0]   amt_hi;
        logic [W-1:0] part;
        logic         err;
    } s1_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
`ifdef SHIFT_ROTATE_EN
            3'b011, 3'b100:         op_legal = 1'b1;
`endif
            default:                op_legal = 1'b0;
        endcase
    endfunction

    // vld_pipe[1] = stage 1 valid, vld_pipe[2] = out_valid; bit 0 is the accept strobe.
    logic [STAGES:0]                 vld_pipe;
    s1_t                             s1;
    logic                            s2_adv;
    logic                            accept;
    logic                            in_legal;

    logic [STAGES-1:0][2:0]          step_op;
    logic [STAGES-1:0][W-1:0]        step_in;
    logic [STAGES-1:0][1:0]          step_amt;
    logic [STAGES-1:0][W-1:0]        step_out;

    assign s2_adv      = !vld_pipe[2] || out_ready;
    assign in_ready    = !vld_pipe[1] || s2_adv;
    assign accept      = in_valid && in_ready;
    assign vld_pipe[0] = accept;
    assign in_legal    = op_legal(Op);

    assign step_op[0]  = Op;
    assign step_in[0]  = In;
    assign step_amt[0] = ShAmt[1:0];
    assign step_op[1]  = s1.op;
    assign step_in[1]  = s1.part;
    assign step_amt[1] = s1.amt_hi;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_step
            shift_pipe_step #(.W(W), .SCALE(2 * g)) u_step (
                .op      (step_op[g]),
                .data    (step_in[g]),
                .amt     (step_amt[g]),
                .shifted (step_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            s1                 <= '0;
            result             <= '0;
            err                <= 1'b0;
        end else begin
            // in_ready implies stage 1 is empty or draining, so it may be overwritten.
            if (in_ready) begin
                vld_pipe[1] <= vld_pipe[0];
            end
            if (accept) begin
                s1.op     <= Op;
                s1.amt_hi <= ShAmt[3:2];
                s1.err    <= !in_legal;
                s1.part   <= in_legal ? step_out[0] : '0;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    result <= s1.err ? '0 : step_out[1];
                    err    <= s1.err;
                end
            end
        end
    end

    assign out_valid = vld_pipe[2];
endmodule

// File: tb/tb_shift_pipe_stage.sv
// Directed bench for shift_pipe_stage: shifts, rotates, illegal ops, backpressure, reset.
module tb_shift_pipe_stage;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] In;
    logic [3:0]  ShAmt;
    logic [2:0]  Op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] got[$];

    localparam logic [2:0] SLL = 3'b000, SRL = 3'b001, SRA = 3'b010,
                           ROL = 3'b011, ROR = 3'b100, BAD = 3'b111;

    shift_pipe_stage #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .ShAmt     (ShAmt),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && out_valid && out_ready) got.push_back(result);

    // Holds an operation on the input until it is accepted; returns at accept edge + 1.
    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt);
        int n;
        logic acc;
        Op = op; In = d; ShAmt = amt; in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready never 1 for op %0d in %h", op, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Op = SLL; In = '0; ShAmt = '0;
        #12;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h want 0000", result); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_sll_latency();
        out_ready = 1'b1;
        send(SLL, 16'h00F1, 4'd4);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sll_early_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sll_valid: got %b want 1", out_valid); end
        vectors++; if (result !== 16'h0F10) begin miscompares++; $display("FAIL sll_result: got %h want 0f10", result); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL sll_err: got %b want 0", err); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sll_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_shift_rotate();
        logic [2:0]  ops  [5];
        logic [15:0] ins  [5];
        logic [3:0]  amts [5];
        logic [15:0] exps [5];
        logic        errs [5];
        ops[0] = SRA; ins[0] = 16'h8010; amts[0] = 4'd3; exps[0] = 16'hF002; errs[0] = 1'b0;
        ops[1] = SRL; ins[1] = 16'h8010; amts[1] = 4'd3; exps[1] = 16'h1002; errs[1] = 1'b0;
        ops[2] = SRA; ins[2] = 16'h8421; amts[2] = 4'd0; exps[2] = 16'h8421; errs[2] = 1'b0;
        ops[3] = ROL; ins[3] = 16'h8001; amts[3] = 4'd1;
        ops[4] = ROR; ins[4] = 16'h1234; amts[4] = 4'd4;
`ifdef SHIFT_ROTATE_EN
        exps[3] = 16'h0003; errs[3] = 1'b0;
        exps[4] = 16'h4123; errs[4] = 1'b0;
`else
        exps[3] = 16'h0000; errs[3] = 1'b1;
        exps[4] = 16'h0000; errs[4] = 1'b1;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(ops[i], ins[i], amts[i]);
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL vec%0d_valid: got %b want 1", i, out_valid); end
            vectors++; if (result !== exps[i]) begin miscompares++; $display("FAIL vec%0d_result: got %h want %h", i, result, exps[i]); end
            vectors++; if (err !== errs[i]) begin miscompares++; $display("FAIL vec%0d_err: got %b want %b", i, err, errs[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(BAD, 16'hFFFF, 4'd0);
        send(SLL, 16'h0001, 4'd15);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL illegal_valid: got %b want 1", out_valid); end
        vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL illegal_result: got %h want 0000", result); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", err); end
        @(posedge clk); #1;
        vectors++; if (result !== 16'h8000) begin miscompares++; $display("FAIL after_illegal_result: got %h want 8000", result); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL after_illegal_err: got %b want 0", err); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL illegal_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        got.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(SLL, 16'(i), 4'd1);
            end
            begin
                int n;
                n = 0;
                while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
                for (int k = 0; k < 3; k++) begin
                    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall%0d_in_ready: got %b want 0", k, in_ready); end
                    vectors++; if (result !== 16'h0002) begin miscompares++; $display("FAIL stall%0d_result: got %h want 0002", k, result); end
                    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall%0d_valid: got %b want 1", k, out_valid); end
                    if (k < 2) begin @(posedge clk); #1; end
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) begin @(posedge clk); #1; end
        vectors++; if (got.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 16'(2 * (i + 1))) begin
                miscompares++; $display("FAIL b2b_order%0d: got %h want %h", i, got[i], 16'(2 * (i + 1)));
            end
        end
    endtask

    task automatic test_reset_in_flight();
        got.delete();
        out_ready = 1'b0;
        send(SLL, 16'h0001, 4'd1);
        send(SLL, 16'h0003, 4'd1);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
        vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL async_rst_result: got %h want 0000", result); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL async_rst_err: got %b want 0", err); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL stale_results: got %0d want 0", got.size()); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_sll_latency();
        test_shift_rotate();
        test_illegal();
        test_back_to_back();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
